// File: rtl/lut_arb_pkg.sv
// Shared constants and sizing helper for the R-channel LUT arbiter.
package lut_arb_pkg;
   localparam int LUT_ADDR_WIDTH = 10;
   localparam int LUT_DATA_WIDTH = 8;
   localparam int ROM_LAT_NOREG  = 1;
   localparam int ROM_LAT_REG    = 2;

   // Index/counter width; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/lut_rr_pick.sv
// Combinational round-robin picker: first set request scanning ptr, ptr+1, ... mod N.
module lut_rr_pick import lut_arb_pkg::*; #(
   parameter int N  = 2,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   logic [IW-1:0] j;

   // Scan from the farthest slot back to ptr so the closest hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      j     = '0;
      for (int k = N-1; k >= 0; k--) begin
         j = IW'((int'(ptr_i) + k) % N);
         if (req_i[j]) begin
            gnt_o    = '0;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end
endmodule

// File: rtl/r_lut_arbiter.sv
// Round-robin arbiter with burst locking in front of the single-port R LUT ROM;
// read data is tagged back to its requester through a shift pipe matching ROM latency.
module r_lut_arbiter import lut_arb_pkg::*; #(
   parameter int N_REQ      = 2,
   parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
   parameter int DATA_WIDTH = LUT_DATA_WIDTH,
   parameter int ROM_LAT    = ROM_LAT_NOREG,
   parameter int LOCK_MAX   = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        arb_en,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ-1:0]            req_lock,
   input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]       rsp_data,
   output logic [ADDR_WIDTH-1:0]       rom_addr,
   output logic                        rom_rst,
   input  logic [DATA_WIDTH-1:0]       rom_rd_data
);
   localparam int IW = idx_w(N_REQ);
   localparam int BW = idx_w(LOCK_MAX);
   localparam logic [BW-1:0] BURST_TOP = BW'(LOCK_MAX - 1);

   logic [IW-1:0]              ptr_q, ptr_d, owner_q, owner_d, gnt_idx, pick_idx;
   logic [BW-1:0]              burst_q, burst_d;
   logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic [N_REQ-1:0]           gnt, pick_gnt, owner_oh;
   logic [ROM_LAT:0][N_REQ-1:0] tag_q;
   logic                       others, hold, xfer;

   lut_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx)
   );

   assign owner_oh = N_REQ'(1) << owner_q;
   assign others   = |(req_valid & ~owner_oh);
   // The lock survives only until the burst cap is hit while someone else waits.
   assign hold     = req_valid[owner_q] & req_lock[owner_q] & ((burst_q < BURST_TOP) | ~others);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      if (rst_n && arb_en) begin
         if (hold) begin
            gnt     = owner_oh;
            gnt_idx = owner_q;
         end else begin
            gnt     = pick_gnt;
            gnt_idx = pick_idx;
         end
      end
   end

   assign xfer = |gnt;

   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      burst_d = burst_q;
      addr_d  = addr_q;
      if (xfer) begin
         addr_d  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
         ptr_d   = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
         burst_d = (gnt_idx != owner_q)  ? '0 :
                   (burst_q == BURST_TOP) ? burst_q : burst_q + 1'b1;
         owner_d = gnt_idx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         owner_q <= '0;
         burst_q <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         burst_q <= burst_d;
         addr_q  <= addr_d;
         tag_q   <= {tag_q[ROM_LAT-1:0], gnt};
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = tag_q[ROM_LAT];
   assign rsp_data  = rom_rd_data;
   assign rom_addr  = addr_q;
   assign rom_rst   = ~rst_n;
endmodule
